// File: rtl/hsi_com_redund_ctrl.sv
// N-line command redundancy controller: steers cd_q onto one idle-high command line,
// rotates across enabled lines on switch requests and faults once the switch budget is spent.
module hsi_com_redund_ctrl #(
   parameter int unsigned N_CH   = 2,
   parameter int unsigned CH_W   = 1,
   parameter int unsigned MAX_SW = 3,
   parameter int unsigned CNT_W  = 2,
   parameter int unsigned STICKY = 0
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clr,
   input  logic [CH_W-1:0]  base_ch,
   input  logic [N_CH-1:0]  ch_en,
   input  logic             switch_req,
   input  logic             frame_to_reply_end,
   input  logic             cd_q,
   output logic [N_CH-1:0]  com,
   output logic [CH_W-1:0]  curr_ch,
   output logic             switched,
   output logic             fault,
   output logic [CNT_W-1:0] sw_cnt
);

   // One spare bit so curr_ch + k never overflows before the modulo-N_CH fold.
   localparam int unsigned IDX_W = CH_W + 1;

   generate
      if (N_CH < 2 || N_CH > 8) begin : g_bad_nch
         $error("hsi_com_redund_ctrl: N_CH must be 2..8");
      end
      if (N_CH > (1 << CH_W)) begin : g_bad_chw
         $error("hsi_com_redund_ctrl: CH_W too narrow for N_CH");
      end
      if (MAX_SW < 1 || MAX_SW > ((1 << CNT_W) - 1)) begin : g_bad_max
         $error("hsi_com_redund_ctrl: MAX_SW out of range for CNT_W");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BASE  = 2'd1,
      ST_SW    = 2'd2,
      ST_FAULT = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [CH_W-1:0]  curr_ch_q, curr_ch_d;
   logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;
   logic             switched_q, switched_d;
   logic             fault_q, fault_d;

   logic [IDX_W-1:0] scan_idx;
   logic [CH_W-1:0]  tgt_ch;
   logic             tgt_found;
   logic [N_CH-1:0]  sel_c;
   logic             drive_c;

   // Next enabled line after curr_ch, wrapping at N_CH; curr_ch itself is never a target.
   always_comb begin
      tgt_found = 1'b0;
      tgt_ch    = '0;
      scan_idx  = '0;
      for (int unsigned k = 1; k < N_CH; k++) begin
         scan_idx = IDX_W'(curr_ch_q) + IDX_W'(k);
         if (scan_idx >= IDX_W'(N_CH)) begin
            scan_idx = scan_idx - IDX_W'(N_CH);
         end
         if (!tgt_found && (scan_idx < IDX_W'(N_CH)) &&
             (|(ch_en & (N_CH'(1) << scan_idx)))) begin
            tgt_found = 1'b1;
            tgt_ch    = scan_idx[CH_W-1:0];
         end
      end
   end

   // Line drive: only the active, enabled line carries cd_q; everything else idles high.
   always_comb begin
      sel_c   = N_CH'(1) << curr_ch_q;
      drive_c = ((state_q == ST_BASE) || (state_q == ST_SW)) && (|(ch_en & sel_c));
      com     = '1;
      if (drive_c && !cd_q) begin
         com = ~sel_c;
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d    = state_q;
      curr_ch_d  = curr_ch_q;
      sw_cnt_d   = sw_cnt_q;
      switched_d = 1'b0;
      fault_d    = 1'b0;

      if (clr) begin
         state_d   = ST_IDLE;
         curr_ch_d = '0;
         sw_cnt_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d   = ST_BASE;
               curr_ch_d = base_ch;
            end
            ST_BASE, ST_SW: begin
               if (switch_req) begin
                  if ((sw_cnt_q == CNT_W'(MAX_SW)) || !tgt_found) begin
                     state_d = ST_FAULT;
                  end else begin
                     state_d   = ST_SW;
                     curr_ch_d = tgt_ch;
                     sw_cnt_d  = sw_cnt_q + CNT_W'(1);
                  end
               end else begin
                  if (frame_to_reply_end) begin
                     sw_cnt_d = '0;
                     if (STICKY == 0) begin
                        state_d = ST_BASE;
                     end
                  end
                  if (state_d == ST_BASE) begin
                     curr_ch_d = base_ch;
                  end
               end
            end
            ST_FAULT: begin
               state_d = ST_FAULT;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      switched_d = (state_d == ST_SW) && (curr_ch_d != base_ch);
      fault_d    = (state_d == ST_FAULT);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= ST_IDLE;
         curr_ch_q  <= '0;
         sw_cnt_q   <= '0;
         switched_q <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         curr_ch_q  <= curr_ch_d;
         sw_cnt_q   <= sw_cnt_d;
         switched_q <= switched_d;
         fault_q    <= fault_d;
      end
   end

   assign curr_ch  = curr_ch_q;
   assign switched = switched_q;
   assign fault    = fault_q;
   assign sw_cnt   = sw_cnt_q;

endmodule

// File: tb/tb_hsi_com_redund_ctrl.sv
// Bench for hsi_com_redund_ctrl: revert and sticky instances (N_CH=4) run side by side
// against a rule-level reference model, with directed scenarios followed by random traffic.
module tb_hsi_com_redund_ctrl;

   localparam int N      = 4;
   localparam int MAX_SW = 3;
   localparam int P_IDLE = 0, P_BASE = 1, P_SW = 2, P_FAULT = 3;

   logic       clk = 1'b0;
   logic       n_rst, clr, switch_req, frame_to_reply_end, cd_q;
   logic [1:0] base_ch;
   logic [3:0] ch_en;

   logic [3:0] com0, com1;
   logic [1:0] curr0, curr1, cnt0, cnt1;
   logic       sw0, sw1, flt0, flt1;

   int errors = 0;
   int checks = 0;

   int m_ph[2];
   int m_ch[2];
   int m_cnt[2];
   bit m_swd[2];

   always #5 clk = ~clk;

   hsi_com_redund_ctrl #(.N_CH(4), .CH_W(2), .MAX_SW(3), .CNT_W(2), .STICKY(0)) u_dut0 (
      .clk(clk), .n_rst(n_rst), .clr(clr), .base_ch(base_ch), .ch_en(ch_en),
      .switch_req(switch_req), .frame_to_reply_end(frame_to_reply_end), .cd_q(cd_q),
      .com(com0), .curr_ch(curr0), .switched(sw0), .fault(flt0), .sw_cnt(cnt0)
   );

   hsi_com_redund_ctrl #(.N_CH(4), .CH_W(2), .MAX_SW(3), .CNT_W(2), .STICKY(1)) u_dut1 (
      .clk(clk), .n_rst(n_rst), .clr(clr), .base_ch(base_ch), .ch_en(ch_en),
      .switch_req(switch_req), .frame_to_reply_end(frame_to_reply_end), .cd_q(cd_q),
      .com(com1), .curr_ch(curr1), .switched(sw1), .fault(flt1), .sw_cnt(cnt1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int next_target(input int from, input logic [3:0] en);
      for (int k = 1; k < N; k++) begin
         int i;
         i = (from + k) % N;
         if (((en >> i) & 4'd1) != 4'd0) return i;
      end
      return -1;
   endfunction

   function automatic logic [3:0] exp_com(input int s);
      logic [3:0] r;
      r = 4'hF;
      if ((m_ph[s] == P_BASE || m_ph[s] == P_SW) && (((ch_en >> m_ch[s]) & 4'd1) != 4'd0)
          && !cd_q) begin
         r = ~(4'd1 << m_ch[s]);
      end
      return r;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         m_ph[s]  = P_IDLE;
         m_ch[s]  = 0;
         m_cnt[s] = 0;
         m_swd[s] = 1'b0;
      end
   endtask

   task automatic model_step();
      for (int s = 0; s < 2; s++) begin
         if (clr) begin
            m_ph[s]  = P_IDLE;
            m_ch[s]  = 0;
            m_cnt[s] = 0;
         end else if (m_ph[s] == P_IDLE) begin
            m_ph[s] = P_BASE;
            m_ch[s] = int'(base_ch);
         end else if (m_ph[s] != P_FAULT) begin
            if (switch_req) begin
               int t;
               t = next_target(m_ch[s], ch_en);
               if (m_cnt[s] == MAX_SW || t < 0) begin
                  m_ph[s] = P_FAULT;
               end else begin
                  m_ch[s] = t;
                  m_cnt[s]++;
                  m_ph[s] = P_SW;
               end
            end else begin
               if (frame_to_reply_end) begin
                  m_cnt[s] = 0;
                  if (s == 0) m_ph[s] = P_BASE;
               end
               if (m_ph[s] == P_BASE) m_ch[s] = int'(base_ch);
            end
         end
         m_swd[s] = (m_ph[s] == P_SW) && (m_ch[s] != int'(base_ch));
      end
   endtask

   task automatic check_inst(input int s);
      logic [3:0] c;
      logic [1:0] ch, n;
      logic       w, f;
      string      p;
      if (s == 0) begin
         c = com0; ch = curr0; n = cnt0; w = sw0; f = flt0; p = "rev";
      end else begin
         c = com1; ch = curr1; n = cnt1; w = sw1; f = flt1; p = "stk";
      end
      chk({p, ".com"},      32'(c),  32'(exp_com(s)));
      chk({p, ".curr_ch"},  32'(ch), 32'(m_ch[s]));
      chk({p, ".sw_cnt"},   32'(n),  32'(m_cnt[s]));
      chk({p, ".switched"}, 32'(w),  32'(m_swd[s]));
      chk({p, ".fault"},    32'(f),  32'(m_ph[s] == P_FAULT));
   endtask

   task automatic apply(input logic c, input logic sr, input logic fe, input logic cd,
                        input logic [3:0] en, input logic [1:0] b);
      clr                = c;
      switch_req         = sr;
      frame_to_reply_end = fe;
      cd_q               = cd;
      ch_en              = en;
      base_ch            = b;
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_inst(0);
      check_inst(1);
   endtask

   task automatic async_reset();
      #2 n_rst = 1'b0;
      #1 model_reset();
      check_inst(0);
      check_inst(1);
      @(negedge clk);
      n_rst = 1'b1;
   endtask

   int         rot_ch[3] = '{3, 0, 1};
   int         rot_sw[3] = '{1, 1, 0};
   logic       r_clr;
   logic [1:0] r_base;
   logic [3:0] r_en;

   initial begin
      n_rst = 1'b0;
      apply(1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 2'd2);
      model_reset();
      repeat (2) @(negedge clk);
      check_inst(0);
      check_inst(1);
      chk("rst.com", 32'(com0), 32'h0000000F);
      chk("rst.cnt", 32'(cnt1), 32'd0);

      // Base drive: one IDLE cycle idles high, then line 2 follows cd_q.
      n_rst = 1'b1;
      #1 chk("idle.com0", 32'(com0), 32'h0000000F);
      chk("idle.com1", 32'(com1), 32'h0000000F);
      step();
      chk("base.curr", 32'(curr0), 32'd2);
      chk("base.com_lo", 32'(com0), 32'b1011);
      cd_q = 1'b1;
      #1 chk("base.com_hi", 32'(com0), 32'hF);
      check_inst(0);
      for (int i = 0; i < 4; i++) begin
         cd_q = i[0];
         step();
         chk("base.com_tog", 32'(com0), i[0] ? 32'hF : 32'b1011);
      end

      // Rotation across a masked line with wrap at N.
      apply(1'b0, 1'b0, 1'b0, 1'b1, 4'b1011, 2'd1);
      step();
      chk("rot.start", 32'(curr0), 32'd1);
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, 1'b1, 1'b0, 1'b1, 4'b1011, 2'd1);
         step();
         chk("rot.curr", 32'(curr0), 32'(rot_ch[i]));
         chk("rot.cnt", 32'(cnt0), 32'(i + 1));
         chk("rot.sw", 32'(sw0), 32'(rot_sw[i]));
      end

      // Budget exhaustion, reply ignored in FAULT, clr recovers.
      apply(1'b0, 1'b1, 1'b0, 1'b0, 4'b1011, 2'd1);
      step();
      chk("fault.flag", 32'(flt0), 32'd1);
      chk("fault.com", 32'(com0), 32'hF);
      chk("fault.cnt", 32'(cnt0), 32'd3);
      apply(1'b0, 1'b0, 1'b1, 1'b0, 4'b1011, 2'd1);
      step();
      chk("fault.reply_ign", 32'(cnt1), 32'd3);
      chk("fault.hold", 32'(flt1), 32'd1);
      apply(1'b1, 1'b0, 1'b0, 1'b0, 4'b1011, 2'd1);
      step();
      chk("clr.fault", 32'(flt0), 32'd0);
      chk("clr.idle_com", 32'(com0), 32'hF);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 4'b1011, 2'd1);
      step();
      chk("clr.base_com", 32'(com0), 32'b1101);

      // Revert vs sticky after one switch.
      apply(1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 2'd0);
      step();
      apply(1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 2'd0);
      step();
      apply(1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 2'd0);
      step();
      chk("sw1.curr", 32'(curr1), 32'd1);
      apply(1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 2'd0);
      step();
      chk("rev.curr", 32'(curr0), 32'd0);
      chk("rev.cnt", 32'(cnt0), 32'd0);
      chk("stk.curr", 32'(curr1), 32'd1);
      chk("stk.cnt", 32'(cnt1), 32'd0);

      // Switch and reply together: switch wins.
      apply(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 2'd0);
      step();
      chk("simul.rev_cnt", 32'(cnt0), 32'd1);
      chk("simul.stk_curr", 32'(curr1), 32'd2);

      // No eligible target: immediate fault.
      apply(1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 2'd0);
      step();
      apply(1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 2'd0);
      step();
      chk("notgt.base_com", 32'(com0), 32'b1110);
      apply(1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 2'd0);
      step();
      chk("notgt.fault", 32'(flt0), 32'd1);

      // Async reset while switched onto line 3.
      apply(1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 2'd0);
      step();
      apply(1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 2'd0);
      step();
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, 1'b1, 1'b0, 1'b1, 4'hF, 2'd0);
         step();
      end
      apply(1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 2'd0);
      step();
      chk("arst.pre_curr", 32'(curr0), 32'd3);
      chk("arst.pre_com", 32'(com0), 32'b0111);
      async_reset();
      chk("arst.com", 32'(com1), 32'hF);
      chk("arst.curr", 32'(curr1), 32'd0);
      step();
      chk("arst.restart", 32'(com0), 32'b1110);

      // Random traffic against the model.
      r_base = 2'd0;
      r_en   = 4'hF;
      for (int cyc = 0; cyc < 600; cyc++) begin
         r_clr = ($urandom_range(0, 31) == 0);
         if (r_clr) r_base = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) r_en = 4'($urandom_range(0, 15));
         apply(r_clr, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
               1'($urandom), r_en, r_base);
         step();
         if ($urandom_range(0, 149) == 0) async_reset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
